// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG byte collector and its FIFO.
package trng_pkg;

    localparam int BYTE_W         = 8;
    localparam int RCT_CUTOFF_DEF = 32;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        VN_FIRST  = 1'b0,
        VN_SECOND = 1'b1
    } vn_state_e;

endpackage

// File: rtl/trng_byte_collector_if.sv
// Byte stream from the collector (master) to the downstream reader (slave).
interface trng_byte_collector_if;
    import trng_pkg::*;

    logic [BYTE_W-1:0] byte_data;
    logic              byte_valid;
    logic              byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);

endinterface

// File: rtl/trng_fifo.sv
// Small synchronous FIFO; a push while full is accepted only when a pop frees a slot on the same edge.
module trng_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] popData_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [LVL_W-1:0] level_q;
    logic             popOk;
    logic             pushOk;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign popOk     = pop_i && !empty_o;
    assign pushOk    = push_i && (!full_o || popOk);
    assign popData_o = mem_q[rdPtr_q];
    assign level_o   = level_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (pushOk) begin
                mem_q[wrPtr_q] <= pushData_i;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({pushOk, popOk})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/trng_byte_collector.sv
// Synchronizes the raw RO bit, runs the repetition-count test, debiases with von Neumann pairs and packs bytes.
// Optional TRNG_RAW_BYPASS_EN adds raw_mode, which skips debiasing while keeping the health test.
module trng_byte_collector
    import trng_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int RCT_CUTOFF  = RCT_CUTOFF_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
`ifdef TRNG_RAW_BYPASS_EN
    input  logic                            raw_mode,
`endif
    input  logic                            raw_bit,
    trng_byte_collector_if.master           stream,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            health_fail,
    output logic                            overflow
);

    localparam logic [7:0] CUTOFF = 8'(RCT_CUTOFF);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sBit;
    logic [7:0]             rctCnt_q, rctCnt_d;
    logic                   prevBit_q, prevBit_d;
    logic                   seen_q, seen_d;
    logic                   healthFail_q, healthFail_d;
    vn_state_e              vnState_q, vnState_d, curState;
    logic                   firstBit_q, firstBit_d;
    logic [BYTE_W-1:0]      shift_q, shift_d;
    logic [2:0]             bitCnt_q, bitCnt_d;
    logic                   overflow_q, overflow_d;
    logic                   emit, emitBit, push, bypass, modeChange;
    logic                   popFire, fifoFull, fifoEmpty;
    logic [BYTE_W-1:0]      headData;

`ifdef TRNG_RAW_BYPASS_EN
    logic rawModePrev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rawModePrev_q <= 1'b0;
        else        rawModePrev_q <= raw_mode;
    end

    assign bypass     = raw_mode;
    assign modeChange = (raw_mode != rawModePrev_q);
`else
    assign bypass     = 1'b0;
    assign modeChange = 1'b0;
`endif

    assign sBit = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            rctCnt_q     <= '0;
            prevBit_q    <= 1'b0;
            seen_q       <= 1'b0;
            healthFail_q <= 1'b0;
            vnState_q    <= VN_FIRST;
            firstBit_q   <= 1'b0;
            shift_q      <= '0;
            bitCnt_q     <= '0;
            overflow_q   <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], raw_bit};
            rctCnt_q     <= rctCnt_d;
            prevBit_q    <= prevBit_d;
            seen_q       <= seen_d;
            healthFail_q <= healthFail_d;
            vnState_q    <= vnState_d;
            firstBit_q   <= firstBit_d;
            shift_q      <= shift_d;
            bitCnt_q     <= bitCnt_d;
            overflow_q   <= overflow_d;
        end
    end

    // The sample that trips the health test is discarded along with any partial byte.
    always_comb begin
        rctCnt_d     = rctCnt_q;
        prevBit_d    = prevBit_q;
        seen_d       = seen_q;
        healthFail_d = healthFail_q;
        curState     = modeChange ? VN_FIRST : vnState_q;
        vnState_d    = curState;
        firstBit_d   = firstBit_q;
        shift_d      = shift_q;
        bitCnt_d     = bitCnt_q;
        emit         = 1'b0;
        emitBit      = 1'b0;
        push         = 1'b0;
        if (!en) begin
            rctCnt_d     = '0;
            seen_d       = 1'b0;
            healthFail_d = 1'b0;
            vnState_d    = VN_FIRST;
            shift_d      = '0;
            bitCnt_d     = '0;
        end else if (healthFail_q) begin
            vnState_d = VN_FIRST;
            shift_d   = '0;
            bitCnt_d  = '0;
        end else begin
            seen_d    = 1'b1;
            prevBit_d = sBit;
            if (!seen_q || sBit != prevBit_q) rctCnt_d = 8'd1;
            else if (rctCnt_q < CUTOFF)       rctCnt_d = rctCnt_q + 8'd1;
            if (rctCnt_d == CUTOFF) begin
                healthFail_d = 1'b1;
                vnState_d    = VN_FIRST;
                shift_d      = '0;
                bitCnt_d     = '0;
            end else begin
                if (bypass) begin
                    emit    = 1'b1;
                    emitBit = sBit;
                end else if (curState == VN_FIRST) begin
                    firstBit_d = sBit;
                    vnState_d  = VN_SECOND;
                end else begin
                    vnState_d = VN_FIRST;
                    if (firstBit_q != sBit) begin
                        emit    = 1'b1;
                        emitBit = firstBit_q;
                    end
                end
                if (emit) begin
                    shift_d  = {shift_q[BYTE_W-2:0], emitBit};
                    bitCnt_d = bitCnt_q + 3'd1;
                    push     = (bitCnt_q == 3'd7);
                end
            end
        end
    end

    assign popFire    = stream.byte_valid && stream.byte_ready;
    assign overflow_d = overflow_q | (push && fifoFull && !popFire);

    trng_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .pushData_i (shift_d),
        .pop_i      (popFire),
        .popData_o  (headData),
        .empty_o    (fifoEmpty),
        .full_o     (fifoFull),
        .level_o    (fifo_level)
    );

    assign stream.byte_data  = headData;
    assign stream.byte_valid = !fifoEmpty;
    assign health_fail       = healthFail_q;
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_trng_byte_collector.sv
// Directed bench for trng_byte_collector: byte scoreboard derived from the sample stream, plus literal checks.
module tb_trng_byte_collector;

    localparam int DEPTH  = 4;
    localparam int CUTOFF = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       raw_bit;
    logic       raw_mode;
    logic [2:0] fifo_level;
    logic       health_fail;
    logic       overflow;

    trng_byte_collector_if sif ();

    trng_byte_collector #(
        .SYNC_STAGES (2),
        .FIFO_DEPTH  (DEPTH),
        .RCT_CUTOFF  (CUTOFF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
`ifdef TRNG_RAW_BYPASS_EN
        .raw_mode    (raw_mode),
`endif
        .raw_bit     (raw_bit),
        .stream      (sif),
        .fifo_level  (fifo_level),
        .health_fail (health_fail),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         popCount = 0;
    bit         stimQ[$];
    logic [7:0] decQ[$];
    logic [7:0] expQ[$];
    bit         expOverflow = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    function automatic void addBits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stimQ.push_back(v[i]);
    endfunction

    // Each data bit becomes a von Neumann pair: 1 -> "10", 0 -> "01".
    function automatic void addVN(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            stimQ.push_back(b[i]);
            stimQ.push_back(!b[i]);
        end
    endfunction

    // Reference: bytes the stimulus must yield, from pair rules and MSB-first packing.
    function automatic void modelBytes(input bit rawMode);
        bit bits[$];
        int acc = 0;
        int cnt = 0;
        decQ.delete();
        if (rawMode) bits = stimQ;
        else
            for (int i = 0; i + 1 < stimQ.size(); i += 2)
                if (stimQ[i] != stimQ[i+1]) bits.push_back(stimQ[i]);
        foreach (bits[k]) begin
            acc = ((acc << 1) | int'(bits[k])) & 255;
            cnt++;
            if (cnt == 8) begin
                decQ.push_back(acc[7:0]);
                acc = 0;
                cnt = 0;
            end
        end
    endfunction

    function automatic void modelPush(input logic [7:0] b, input bit popping);
        if (expQ.size() < DEPTH || popping) expQ.push_back(b);
        else expOverflow = 1'b1;
    endfunction

    // Sample k of stimQ is the one the DUT takes on the k-th enabled edge (2-flop synchronizer lead).
    task automatic applyStimulus(input bit dropEn, input bit readyAtLast);
        int n = stimQ.size();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i < n) raw_bit = stimQ[i];
            en = (i >= 2);
            if (readyAtLast && i == n + 1) sif.byte_ready = 1'b1;
        end
        @(negedge clk);
        if (dropEn) en = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        sif.byte_ready = 1'b1;
        while ((expQ.size() != 0 || sif.byte_valid) && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        checkOutput(name, 32'(n < 200), 32'd1);
    endtask

    // Every pop is checked against the scoreboard; a stalled head must hold its value.
    logic [7:0] prevData = '0;
    bit         prevStall = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall && sif.byte_valid) checkOutput("stall_hold", sif.byte_data, prevData);
                if (sif.byte_valid && sif.byte_ready) begin
                    popCount++;
                    if (expQ.size() == 0) checkOutput("unexpected_pop", sif.byte_data, 32'hFFFF_FFFF);
                    else                  checkOutput("pop_data", sif.byte_data, expQ.pop_front());
                end
                prevStall = sif.byte_valid && !sif.byte_ready;
                prevData  = sif.byte_data;
            end
        end
    end

    initial begin
        int pops0;
        rst_n = 1'b0;
        en = 1'b0;
        raw_bit = 1'b0;
        raw_mode = 1'b0;
        sif.byte_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", sif.byte_valid, 0);
        checkOutput("rst_data", sif.byte_data, 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_health", health_fail, 0);
        checkOutput("rst_overflow", overflow, 0);
        rst_n = 1'b1;

        $display("[TB] debias pairs");
        stimQ.delete();
        addBits(32'h92799, 20);
        modelBytes(1'b0);
        checkOutput("model_count", decQ.size(), 1);
        checkOutput("model_byte", decQ[0], 8'hAA);
        foreach (decQ[k]) modelPush(decQ[k], 1'b0);
        pops0 = popCount;
        sif.byte_ready = 1'b1;
        applyStimulus(1'b1, 1'b0);
        waitDrain("debias_drain");
        checkOutput("debias_pops", popCount - pops0, 1);
        checkOutput("debias_level", fifo_level, 0);

        $display("[TB] repetition count");
        raw_bit = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (CUTOFF - 1) @(negedge clk);
        checkOutput("rct_below", health_fail, 0);
        @(negedge clk);
        checkOutput("rct_trip", health_fail, 1);
        repeat (4) @(negedge clk);
        checkOutput("rct_sticky", health_fail, 1);
        checkOutput("rct_nopush", fifo_level, 0);
        en = 1'b0;
        @(negedge clk);
        checkOutput("rct_clear", health_fail, 0);

        $display("[TB] backpressure");
        sif.byte_ready = 1'b0;
        stimQ.delete();
        for (int b = 1; b <= 5; b++) addVN(8'(b * 8'h11));
        modelBytes(1'b0);
        checkOutput("model_bp_count", decQ.size(), 5);
        foreach (decQ[k]) modelPush(decQ[k], 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("bp_level", fifo_level, DEPTH);
        checkOutput("bp_overflow", overflow, 32'(expOverflow));
        checkOutput("bp_head", sif.byte_data, 8'h11);
        pops0 = popCount;
        waitDrain("bp_drain");
        checkOutput("bp_pops", popCount - pops0, 4);
        checkOutput("bp_overflow_sticky", overflow, 1);

        $display("[TB] reset mid-byte");
        sif.byte_ready = 1'b0;
        stimQ.delete();
        addVN(8'h5A);
        addVN(8'hC3);
        addBits(32'hAA, 8);
        modelBytes(1'b0);
        foreach (decQ[k]) modelPush(decQ[k], 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pre_rst_level", fifo_level, 2);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", sif.byte_valid, 0);
        checkOutput("mid_rst_level", fifo_level, 0);
        checkOutput("mid_rst_health", health_fail, 0);
        checkOutput("mid_rst_overflow", overflow, 0);
        expQ.delete();
        expOverflow = 1'b0;
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stimQ.delete();
        addVN(8'h3C);
        modelBytes(1'b0);
        foreach (decQ[k]) modelPush(decQ[k], 1'b0);
        pops0 = popCount;
        sif.byte_ready = 1'b1;
        applyStimulus(1'b1, 1'b0);
        waitDrain("fresh_drain");
        checkOutput("fresh_pops", popCount - pops0, 1);

        $display("[TB] full with simultaneous pop");
        sif.byte_ready = 1'b0;
        stimQ.delete();
        for (int b = 1; b <= 4; b++) addVN(8'(b));
        modelBytes(1'b0);
        foreach (decQ[k]) modelPush(decQ[k], 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("full_level", fifo_level, DEPTH);
        stimQ.delete();
        addVN(8'h05);
        modelBytes(1'b0);
        foreach (decQ[k]) modelPush(decQ[k], 1'b1);
        pops0 = popCount;
        applyStimulus(1'b1, 1'b1);
        checkOutput("swap_level", fifo_level, DEPTH);
        checkOutput("swap_overflow", overflow, 0);
        waitDrain("swap_drain");
        checkOutput("swap_pops", popCount - pops0, 5);

`ifdef TRNG_RAW_BYPASS_EN
        $display("[TB] raw bypass");
        raw_mode = 1'b1;
        stimQ.delete();
        addBits(32'hAA, 8);
        modelBytes(1'b1);
        checkOutput("model_raw", decQ[0], 8'hAA);
        foreach (decQ[k]) modelPush(decQ[k], 1'b0);
        pops0 = popCount;
        sif.byte_ready = 1'b1;
        applyStimulus(1'b1, 1'b0);
        waitDrain("raw_drain");
        checkOutput("raw_pops", popCount - pops0, 1);
        raw_mode = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trng_byte_collector.md
Name: trng_byte_collector

Overview:
- Consumer end of the ring-oscillator entropy path: samples the raw RO bit asynchronously to `clk`, synchronizes it, runs a repetition-count health test, and applies von Neumann debiasing.
- Packs accepted bits into bytes and buffers them in a small FIFO.
- Bytes leave on a valid/ready stream for a downstream reader (host I/O or register interface).
- Sits between the ring oscillator and the chip outputs.

Parameters:
- SYNC_STAGES, 2: flops in the raw-bit synchronizer (minimum 2).
- FIFO_DEPTH, 4: byte FIFO entries (power of two, at least 2).
- RCT_CUTOFF, 32: consecutive identical synced samples that trip the health test (range 2..255).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  collector enable; low clears collector state and `health_fail`.
- raw_bit  input  1  raw ring-oscillator output, asynchronous to `clk`.
- byte_data  output  8  FIFO head byte.
- byte_valid  output  1  FIFO non-empty.
- byte_ready  input  1  downstream accepts `byte_data`.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- health_fail  output  1  sticky repetition-count failure.
- overflow  output  1  sticky: a completed byte was dropped because the FIFO was full.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all flops 0, so `byte_valid`=0, `byte_data`=0, `fifo_level`=0, `health_fail`=0, `overflow`=0. Reset mid-byte discards the partial byte and all FIFO contents.
- Synchronizer: `raw_bit` passes through SYNC_STAGES flops, free-running regardless of `en`. `s_bit` is the last stage.
- Sampling: one `s_bit` sample per cycle while `en`=1 and `health_fail`=0.
- Repetition count test:
  - Counter `rct_cnt` (8 bits) is set to 1 on the first sample and on any change from the previous sample; otherwise it increments, saturating at RCT_CUTOFF.
  - When `rct_cnt` reaches RCT_CUTOFF, `health_fail` sets on that same edge.
  - While `health_fail`=1: no sampling, the partial byte is discarded, FIFO contents remain poppable.
  - `en`=0 clears `health_fail`, `rct_cnt`, pair state, shift register and bit count. FIFO and `overflow` are untouched.
- Von Neumann pair FSM (`VN_FIRST` -> `VN_SECOND` -> `VN_FIRST`):
  - `VN_FIRST`: latch the sample.
  - `VN_SECOND`: pair 10 emits 1, pair 01 emits 0, pairs 00 and 11 emit nothing.
- Packing:
  - Emitted bits shift in at bit 0, shifting left, so the first emitted bit ends in bit 7.
  - A 3-bit counter tracks bits. The 8th emitted bit completes the byte; the counter wraps to 0.
- FIFO push/pop:
  - Byte completion pushes in the same edge that shifts in the 8th bit, so `byte_valid` rises one cycle after that edge.
  - Pop occurs on `byte_valid` and `byte_ready`.
  - Push is accepted if not full, or if full and popping in the same cycle; `fifo_level` is unchanged in that case.
  - A push while full without a pop drops the byte and sets `overflow`. `overflow` clears only on reset.
  - Push and pop on an empty FIFO: the push lands; nothing is popped, since `byte_valid` was 0.
  - `byte_data` is stable while `byte_valid`=1 and `byte_ready`=0.
- Latency: a `raw_bit` change is visible in `s_bit` after SYNC_STAGES edges.

Optional Feature:
- Macro: `TRNG_RAW_BYPASS_EN`.
- Defined: adds input port `raw_mode` (1 bit). When `raw_mode`=1, von Neumann is bypassed and every sampled bit is emitted. The repetition count test still applies. Changing `raw_mode` resets the pair FSM to `VN_FIRST`; the bit counter is kept.
- Undefined: no `raw_mode` port; debiasing is always active.

Decomposition:
- Package `trng_pkg`: pair-FSM enum (`VN_FIRST`, `VN_SECOND`), `BYTE_W`=8, default RCT_CUTOFF and FIFO_DEPTH constants.
- Sub-module `trng_fifo`: synchronous FIFO with width and depth parameters, push/pop/full/empty/level. The top holds the synchronizer, RCT, pair FSM and packer.

Test Plan:
- Reset: assert `rst_n`=0 mid-byte with 2 bytes queued -> `byte_valid`=0, `fifo_level`=0, `health_fail`=0, `overflow`=0 immediately; after release, the next byte is built from fresh bits only.
- Debias: `en`=1, `byte_ready`=1, synced pairs 10,01,00,10,01,11,10,01,10,01 -> exactly one byte 0xAA; pairs 00/11 produce nothing; `fifo_level` returns to 0.
- Health test: `raw_bit` held 1 for 32 synced samples (RCT_CUTOFF=32) -> `health_fail`=1 on the 32nd sample edge, no bytes pushed; `en`=0 for one cycle -> `health_fail`=0.
- Backpressure: `byte_ready`=0, generate 5 bytes 0x11..0x55 (FIFO_DEPTH=4) -> `fifo_level`=4, `overflow`=1; then `byte_ready`=1 pops 0x11,0x22,0x33,0x44 in order.
- Full with simultaneous pop: FIFO full, byte completes while `byte_ready`=1 -> `fifo_level` stays 4, `overflow` remains 0.
- Bypass (`TRNG_RAW_BYPASS_EN`): `raw_mode`=1, synced samples 1,0,1,0,1,0,1,0 -> byte 0xAA after 8 samples.
